// File: rtl/ltssm_detect_if.sv
// PIPE receiver-detect signal bundle between the Detect substate machine and the PHY.
interface ltssm_detect_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   lane_active_i;
  logic [N-1:0]   rx_elec_idle_i;
  logic [N-1:0]   phy_status_i;
  logic [3*N-1:0] rx_status_i;
  logic [N-1:0]   txdetectrx_o;
  logic [N-1:0]   tx_elec_idle_o;
  logic [N-1:0]   lanes_detected_o;
  logic           done_o;

  // Detect machine side
  modport master (
    input  lane_active_i, rx_elec_idle_i, phy_status_i, rx_status_i,
    output txdetectrx_o, tx_elec_idle_o, lanes_detected_o, done_o
  );

  // PHY / top-level LTSSM side
  modport slave (
    output lane_active_i, rx_elec_idle_i, phy_status_i, rx_status_i,
    input  txdetectrx_o, tx_elec_idle_o, lanes_detected_o, done_o
  );
endinterface

// File: rtl/ltssm_detect.sv
// LTSSM Detect.Quiet / Detect.Active substate machine; hands the detected lane set to Polling.
module ltssm_detect #(
  parameter int unsigned MAX_NUM_LANES         = 4,
  parameter int unsigned TIMEOUT_12MS_CYCLES   = 1_500_000,
  parameter int unsigned DETECT_TIMEOUT_CYCLES = 2_500
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  ltssm_detect_if.master       pipe
);
  localparam int unsigned N       = MAX_NUM_LANES;
  localparam int unsigned TIMER_W = 32;
  localparam logic [TIMER_W-1:0] QUIET_LAST  = TIMER_W'(TIMEOUT_12MS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DETECT_LAST = TIMER_W'(DETECT_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_QUIET, ST_ACTIVE, ST_WAIT, ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
  logic                 second_try_q, second_try_d;
  logic [N-1:0]         first_set_q, first_set_d;
  logic [N-1:0]         resp_q, resp_d;
  logic [N-1:0]         det_q, det_d;
  logic [N-1:0]         txdetectrx_q, txdetectrx_d;
  logic [N-1:0]         lanes_detected_q, lanes_detected_d;
  logic                 done_q, done_d;
  logic [N-1:0]         tx_elec_idle_q;

  logic [N-1:0]         det_hit;
  logic [N-1:0]         resp_new;
  logic [N-1:0]         det_new;
  logic [N-1:0]         d_set;
  logic                 elec_break;
  logic                 active_end;

  // Per-lane "receiver present" report: PhyStatus pulse with RxStatus 3'b011
  always_comb begin
    det_hit = '0;
    for (int k = 0; k < int'(N); k++) begin
      det_hit[k] = pipe.phy_status_i[k] && (pipe.rx_status_i[3*k +: 3] == 3'b011);
    end
  end

  assign timer_inc  = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + TIMER_W'(1);
  assign resp_new   = resp_q | (pipe.phy_status_i & pipe.lane_active_i);
  assign det_new    = det_q  | (det_hit & pipe.lane_active_i);
  assign d_set      = det_new & pipe.lane_active_i;
  assign elec_break = |(pipe.lane_active_i & ~pipe.rx_elec_idle_i);
  assign active_end = ((resp_new & pipe.lane_active_i) == pipe.lane_active_i) ||
                      (timer_q == DETECT_LAST);

  // Next-state and next-output logic; en_i low overrides everything
  always_comb begin
    state_d          = state_q;
    timer_d          = timer_inc;
    second_try_d     = second_try_q;
    first_set_d      = first_set_q;
    resp_d           = resp_q;
    det_d            = det_q;
    txdetectrx_d     = txdetectrx_q;
    lanes_detected_d = lanes_detected_q;
    done_d           = done_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (en_i) state_d = ST_QUIET;
      end
      ST_QUIET: begin
        if (timer_q == QUIET_LAST || elec_break) begin
          state_d      = ST_ACTIVE;
          timer_d      = '0;
          resp_d       = '0;
          det_d        = '0;
          txdetectrx_d = pipe.lane_active_i;
        end
      end
      ST_ACTIVE: begin
        resp_d       = resp_new;
        det_d        = det_new;
        txdetectrx_d = pipe.lane_active_i & ~resp_new;
        if (active_end) begin
          timer_d      = '0;
          txdetectrx_d = '0;
          if (d_set == '0) begin
            state_d      = ST_QUIET;
            second_try_d = 1'b0;
          end else if (d_set == pipe.lane_active_i) begin
            state_d          = ST_DONE;
            lanes_detected_d = d_set;
            done_d           = 1'b1;
          end else if (!second_try_q) begin
            state_d      = ST_WAIT;
            first_set_d  = d_set;
            second_try_d = 1'b1;
          end else if (d_set == first_set_q) begin
            state_d          = ST_DONE;
            lanes_detected_d = d_set;
            done_d           = 1'b1;
          end else begin
            state_d      = ST_QUIET;
            second_try_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        txdetectrx_d = '0;
        if (timer_q == QUIET_LAST) begin
          state_d      = ST_ACTIVE;
          timer_d      = '0;
          resp_d       = '0;
          det_d        = '0;
          txdetectrx_d = pipe.lane_active_i;
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!en_i) begin
      state_d          = ST_IDLE;
      timer_d          = '0;
      second_try_d     = 1'b0;
      first_set_d      = '0;
      resp_d           = '0;
      det_d            = '0;
      txdetectrx_d     = '0;
      lanes_detected_d = '0;
      done_d           = 1'b0;
    end
  end

  // State, timer, flags and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      timer_q          <= '0;
      second_try_q     <= 1'b0;
      first_set_q      <= '0;
      resp_q           <= '0;
      det_q            <= '0;
      txdetectrx_q     <= '0;
      lanes_detected_q <= '0;
      done_q           <= 1'b0;
      tx_elec_idle_q   <= '1;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      second_try_q     <= second_try_d;
      first_set_q      <= first_set_d;
      resp_q           <= resp_d;
      det_q            <= det_d;
      txdetectrx_q     <= txdetectrx_d;
      lanes_detected_q <= lanes_detected_d;
      done_q           <= done_d;
      tx_elec_idle_q   <= '1;
    end
  end

  assign pipe.txdetectrx_o     = txdetectrx_q;
  assign pipe.tx_elec_idle_o   = tx_elec_idle_q;
  assign pipe.lanes_detected_o = lanes_detected_q;
  assign pipe.done_o           = done_q;
endmodule
